// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32 instruction encoder: format codes, the NOP word,
// FSM states and the packer result record. Width macros default here if not preset.
`ifndef INSTR_W
`define INSTR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

package instr_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic        fmt_err;
        logic        range_err;
    } pack_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: (fmt, fields) -> {word, fmt_err, range_err}.
// Immediate range checking is compiled in only when IMM_RANGE_CHECK_EN is defined.
module instr_pack
    import instr_encoder_pkg::*;
#(
    parameter int WORD_W = `WORD_W
) (
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [WORD_W-1:0] imm,
    output pack_t             res
);

    logic range_err;

`ifdef IMM_RANGE_CHECK_EN
    logic signed [WORD_W-1:0] simm;

    assign simm = imm;

    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = (simm < -2048) || (simm > 2047);
            // branch offsets are 13-bit signed and must be halfword aligned
            FMT_B:        range_err = (simm < -4096) || (simm > 4095) || imm[0];
            FMT_U:        range_err = (imm[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        res.word      = 32'h0000_0000;
        res.fmt_err   = 1'b0;
        res.range_err = range_err;
        case (fmt)
            FMT_R:   res.word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   res.word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   res.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   res.word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   res.word = {imm[31:12], rd, opcode};
            default: res.fmt_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32 instruction encoder / instruction-memory loader.
// Optional macro IMM_RANGE_CHECK_EN turns out-of-range immediates into NOP + err.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int INSTR_W = `INSTR_W,
    parameter int WORD_W  = `WORD_W,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W:0]    count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [WORD_W-1:0]  in_imm,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  err_addr
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] addr_cnt;
    logic              start_go;
    logic              accept;
    logic              last_beat;
    logic              bad;
    pack_t             pk;

    instr_pack #(.WORD_W(WORD_W)) u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .res    (pk)
    );

    assign start_go  = (state == ST_IDLE) && start;
    assign accept    = in_valid && in_ready;
    assign last_beat = (remaining == (ADDR_W+1)'(1));
    assign bad       = pk.fmt_err | pk.range_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (accept && last_beat) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_RUN);
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
    end

    // accept -> write register stage: the packed word lands on imem one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            err_addr   <= '0;
            addr_cnt   <= '0;
            remaining  <= '0;
        end else begin
            imem_we <= accept;
            if (start_go) begin
                addr_cnt  <= base_addr;
                remaining <= count;
                err       <= 1'b0;
            end else if (accept) begin
                imem_addr  <= addr_cnt;
                imem_wdata <= bad ? INSTR_W'(NOP_WORD) : INSTR_W'(pk.word);
                addr_cnt   <= addr_cnt + 1'b1;
                remaining  <= remaining - 1'b1;
                if (bad) begin
                    err <= 1'b1;
                    if (!err) begin
                        err_addr <= addr_cnt;
                    end
                end
            end
        end
    end

endmodule
